ov7670_cfg_sequencer: RTL

- Walks the OV7670 register-configuration ROM from address 0 and issues one SCCB register write per ROM entry.
- Honours the ROM's special codes:
  - 16'hFFF0 is a fixed delay.
  - 16'hFFFF is end-of-table.
- Sits between the camera-init trigger logic, the config ROM (1-cycle registered read) and the SCCB master.
- Reports busy/done/error to the top level.

---
 rtl/ov7670_cfg_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register-configuration sequencer: walks the config ROM and issues one
// SCCB write per entry, honouring the delay (FFF0) and end-of-table (FFFF) codes.
module ov7670_cfg_sequencer #(
    parameter int unsigned DELAY_CYCLES = 1_000_000,
    parameter int unsigned GAP_CYCLES   = 1_000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_valid,
    input  logic        sccb_ready,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_done,
    input  logic        sccb_err,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT,
        S_DELAY, S_GAP, S_NEXT, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] DLY_LOAD = (DELAY_CYCLES > 0) ? 32'(DELAY_CYCLES - 1) : '0;
    localparam logic [31:0] GAP_LOAD = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : '0;
    localparam logic [31:0] RETRY_MAX = 32'(MAX_RETRY);

    state_t      state, state_n;
    logic [7:0]  addr_n, reg_n, val_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] retry, retry_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            sccb_reg <= '0;
            sccb_val <= '0;
            cnt      <= '0;
            retry    <= '0;
        end else begin
            state    <= state_n;
            rom_addr <= addr_n;
            sccb_reg <= reg_n;
            sccb_val <= val_n;
            cnt      <= cnt_n;
            retry    <= retry_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = rom_addr;
        reg_n   = sccb_reg;
        val_n   = sccb_val;
        cnt_n   = cnt;
        retry_n = retry;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_FETCH;
                    addr_n  = '0;
                    cnt_n   = '0;
                    retry_n = '0;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (rom_data == 16'hFFFF) begin
                    state_n = S_DONE;
                end else if (rom_data == 16'hFFF0) begin
                    state_n = S_DELAY;
                    cnt_n   = DLY_LOAD;
                end else begin
                    state_n = S_SEND;
                    reg_n   = rom_data[15:8];
                    val_n   = rom_data[7:0];
                end
            end
            S_SEND: begin
                if (sccb_ready) state_n = S_WAIT;
            end
            S_WAIT: begin
                // sccb_err only carries meaning alongside sccb_done
                if (sccb_done) begin
                    if (!sccb_err) begin
                        retry_n = '0;
                        if (GAP_CYCLES == 0) begin
                            state_n = S_NEXT;
                        end else begin
                            state_n = S_GAP;
                            cnt_n   = GAP_LOAD;
                        end
                    end else if (retry < RETRY_MAX) begin
                        state_n = S_SEND;
                        retry_n = retry + 32'd1;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_DELAY, S_GAP: begin
                if (cnt == '0) state_n = S_NEXT;
                else           cnt_n   = cnt - 32'd1;
            end
            S_NEXT: begin
                // a well-formed table terminates before the last address; never wrap
                if (rom_addr == 8'hFF) begin
                    state_n = S_ERR;
                end else begin
                    addr_n  = rom_addr + 8'd1;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign sccb_valid = (state == S_SEND);
    assign busy       = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);

endmodule
